fetch_aligner: RTL

- Sits between instruction memory and the compressed-instruction decompression stage.
- Fetches aligned 32-bit words and buffers halfwords, so instructions may start on any 16-bit boundary.
- Presents one instruction per handshake: 16-bit RVC or 32-bit RVI, with its PC and a compressed flag.
- Handles branch/jump redirects, including redirects to odd-halfword targets and squashing of in-flight fetches.

---
 rtl/fetch_aligner_if.sv | 29 ++
 rtl/fetch_aligner.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_aligner_if.sv
// Fetch-aligner bundle: memory fetch, redirect and instruction-output signals.
// Latency: n/a (wires only).
// Backpressure: inst_ready stalls instruction output; memory accepts every request.
// Ports: mem_req/mem_addr out, mem_valid/mem_rdata in, redirect_valid/redirect_pc in,
//        inst_valid/inst_out/inst_pc/inst_is_compressed out, inst_ready in.
// The master modport is the aligner; the slave modport is its environment.
interface fetch_aligner_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_is_compressed;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_is_compressed,
        input  mem_valid, mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_is_compressed,
        output mem_valid, mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_aligner.sv
// Aligns 32-bit memory words into a 16-bit-granular stream of RVC/RVI instructions.
// Latency: mem_req in the reset-release cycle, first inst_valid two cycles later with 1-cycle memory.
// Backpressure: inst_ready=0 holds the output; fetching stops once 2+ halfwords are buffered.
// Ports: clk, rst (sync, active high); bus (master modport of fetch_aligner_if) carrying the
//        memory request/response, redirect, and instruction valid/ready output.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_aligner_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

    state_t      state;
    logic [47:0] hw_buf;       // up to three halfwords, [15:0] oldest
    logic [1:0]  cnt;          // halfwords held
    logic [31:0] pc_q;         // PC of hw_buf[15:0]
    logic [31:0] fetch_addr;   // next word address to fetch
    logic        drop_low;     // next word starts mid-word after an odd-halfword target

    logic        compressed;
    logic        fire;
    logic        append;
    logic [1:0]  shift_hw;
    logic [1:0]  cnt_shifted;
    logic [1:0]  append_hw;
    logic [1:0]  cnt_next;
    logic [31:0] append_dat;
    logic [47:0] buf_shifted;
    logic [47:0] buf_next;

    assign compressed             = hw_buf[1:0] != 2'b11;
    assign bus.inst_valid         = (cnt >= 2'd1 && compressed) || (cnt >= 2'd2);
    assign bus.inst_out           = compressed ? {16'h0, hw_buf[15:0]} : hw_buf[31:0];
    assign bus.inst_pc            = pc_q;
    assign bus.inst_is_compressed = bus.inst_valid && compressed;
    assign bus.mem_req            = (state == IDLE) && (cnt <= 2'd1) && !bus.redirect_valid && !rst;
    assign bus.mem_addr           = fetch_addr;

    // Consume shifts first; the returning word is then placed right above what remains.
    // Bits above cnt are always zero, so the append can simply be OR-ed in.
    always_comb begin
        fire        = bus.inst_valid && bus.inst_ready;
        shift_hw    = fire ? (compressed ? 2'd1 : 2'd2) : 2'd0;
        buf_shifted = hw_buf >> {shift_hw, 4'b0000};
        cnt_shifted = cnt - shift_hw;
        append      = (state == WAIT) && bus.mem_valid;
        append_dat  = drop_low ? {16'h0, bus.mem_rdata[31:16]} : bus.mem_rdata;
        append_hw   = drop_low ? 2'd1 : 2'd2;
        buf_next    = buf_shifted;
        cnt_next    = cnt_shifted;
        if (append) begin
            buf_next = buf_shifted | ({16'h0, append_dat} << {cnt_shifted, 4'b0000});
            cnt_next = cnt_shifted + append_hw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hw_buf     <= '0;
            cnt        <= 2'd0;
            pc_q       <= RESET_PC & ~32'h1;
            fetch_addr <= RESET_PC & ~32'h3;
            drop_low   <= RESET_PC[1];
        end else if (bus.redirect_valid) begin
            // Redirect wins over consume and append; an in-flight word is squashed.
            hw_buf     <= '0;
            cnt        <= 2'd0;
            pc_q       <= bus.redirect_pc & ~32'h1;
            fetch_addr <= bus.redirect_pc & ~32'h3;
            drop_low   <= bus.redirect_pc[1];
            if (state == WAIT)
                state <= bus.mem_valid ? IDLE : SQUASH;
        end else begin
            hw_buf <= buf_next;
            cnt    <= cnt_next;
            if (fire)
                pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
            case (state)
                IDLE: begin
                    if (bus.mem_req)
                        state <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_valid) begin
                        state      <= IDLE;
                        fetch_addr <= fetch_addr + 32'd4;
                        drop_low   <= 1'b0;
                    end
                end
                SQUASH: begin
                    // The stale response is thrown away here.
                    if (bus.mem_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
